// File: rtl/audio_player_pkg.sv
// Shared types and constants for the audio sample player.
package audio_player_pkg;

    localparam int unsigned DEFAULT_DIVISOR = 1136;
    localparam int unsigned MIN_DIVISOR     = 100;
    localparam int unsigned SAMPLE_W        = 16;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned DIV_W           = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PLAY_LO = 2'd2,
        PLAY_HI = 2'd3
    } state_t;

    // Requested divisors below the floor would starve the fetch path.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIVISOR)) ? DIV_W'(MIN_DIVISOR) : d;
    endfunction

endpackage

// File: rtl/rate_tick_counter.sv
// Free-running sample-period counter; the divisor is only re-sampled at the end
// of a period so a running period is never truncated or stretched.
module rate_tick_counter
    import audio_player_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor_in,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;
    logic [DIV_W-1:0] r_active_div;
    logic             w_tick;

    assign w_tick = enable && (r_count == (r_active_div - DIV_W'(1)));
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count      <= '0;
            r_active_div <= DIV_W'(DEFAULT_DIVISOR);
        end else if (clear) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count      <= '0;
            r_active_div <= clamp_div(divisor_in);
        end else if (enable) begin
            r_count <= r_count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/divisor_sample_clock.sv
// Fetches 32-bit song words over req/ack and plays them as two 16-bit samples,
// one per divided-clock tick (low half first).
module divisor_sample_clock
    import audio_player_pkg::*;
#(
    parameter int unsigned             ADDR_W    = 23,
    parameter logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'('h7FFFF)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DIV_W-1:0]    frequency_divisor,
    input  logic                enable,
    input  logic                restart,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [WORD_W-1:0]   mem_data,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                underrun
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_mem_req;
    logic                w_mem_req_next;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [ADDR_W-1:0]   w_mem_addr_next;
    logic [SAMPLE_W-1:0] r_sample;
    logic [SAMPLE_W-1:0] w_sample_next;
    logic                r_valid;
    logic                w_valid_next;
    logic                r_underrun;
    logic                w_underrun_next;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_word_next;
    logic                w_tick;

    rate_tick_counter u_rate_tick_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .clear      (restart),
        .divisor_in (frequency_divisor),
        .tick       (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_sample   <= '0;
            r_valid    <= 1'b0;
            r_underrun <= 1'b0;
            r_word     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_sample   <= w_sample_next;
            r_valid    <= w_valid_next;
            r_underrun <= w_underrun_next;
            r_word     <= w_word_next;
        end
    end

    // Next-state and registered-output logic; restart overrides every state.
    always_comb begin
        w_state_next    = r_state;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_sample_next   = r_sample;
        w_valid_next    = 1'b0;
        w_underrun_next = 1'b0;
        w_word_next     = r_word;

        if (restart) begin
            w_state_next    = enable ? FETCH : IDLE;
            w_mem_req_next  = 1'b0;
            w_mem_addr_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        w_state_next   = FETCH;
                        w_mem_req_next = 1'b1;
                    end
                end
                FETCH: begin
                    w_mem_req_next  = 1'b1;
                    w_underrun_next = w_tick;
                    if (mem_ack) begin
                        w_word_next    = mem_data;
                        w_mem_req_next = 1'b0;
                        w_state_next   = PLAY_LO;
                    end
                end
                PLAY_LO: begin
                    if (w_tick) begin
                        w_sample_next = r_word[SAMPLE_W-1:0];
                        w_valid_next  = 1'b1;
                        w_state_next  = PLAY_HI;
                    end
                end
                PLAY_HI: begin
                    if (w_tick) begin
                        w_sample_next   = r_word[WORD_W-1:SAMPLE_W];
                        w_valid_next    = 1'b1;
                        w_mem_addr_next = (r_mem_addr == LAST_ADDR) ? '0
                                                                    : r_mem_addr + ADDR_W'(1);
                        w_mem_req_next  = 1'b1;
                        w_state_next    = FETCH;
                    end
                end
                default: begin
                    w_state_next   = IDLE;
                    w_mem_req_next = 1'b0;
                end
            endcase
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_divisor_sample_clock.sv
// Bench for divisor_sample_clock: directed scenarios plus random traffic,
// checked cycle by cycle against a halves-remaining playback model.
module tb_divisor_sample_clock;
    import audio_player_pkg::*;

    localparam int unsigned       ADDR_W = 23;
    localparam logic [ADDR_W-1:0] LAST   = 23'd9;
    localparam int unsigned       VEC_W  = 1 + ADDR_W + 16 + 2;

    logic              clk = 1'b0;
    logic              reset_n, enable, restart, mem_ack;
    logic [31:0]       frequency_divisor, mem_data;
    logic              mem_req, sample_valid, underrun;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       sample_out;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // memory responder controls
    bit          hold, stray, fixed_en;
    int          lat, wcnt;
    logic [31:0] fixed_data, last_ack_data;

    // playback model
    bit                m_started;
    int                m_left;
    int unsigned       m_cnt, m_per;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_word;
    logic [15:0]       m_sample;
    logic              m_valid, m_under, m_req;

    always #10 clk = ~clk;

    divisor_sample_clock #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .frequency_divisor (frequency_divisor),
        .enable            (enable),
        .restart           (restart),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_data          (mem_data),
        .sample_out        (sample_out),
        .sample_valid      (sample_valid),
        .underrun          (underrun)
    );

    function automatic logic [VEC_W-1:0] dut_vec();
        return {mem_req, mem_addr, sample_out, sample_valid, underrun};
    endfunction

    function automatic logic [VEC_W-1:0] exp_vec();
        return {m_req, m_addr, m_sample, m_valid, m_under};
    endfunction

    task automatic model_reset();
        m_started = 0; m_left = 0; m_cnt = 0; m_per = 1136;
        m_addr = '0; m_word = '0; m_sample = '0;
        m_valid = 0; m_under = 0; m_req = 0;
        wcnt = 0;
    endtask

    // One clock of behaviour: tick every m_per enabled cycles; a word gives two halves.
    task automatic model_step();
        bit t;
        t = enable && (m_cnt == m_per - 1);
        m_valid = 0;
        m_under = 0;
        if (restart) begin
            m_cnt = 0; m_left = 0; m_started = enable; m_addr = '0; m_req = 0;
            return;
        end
        if (t) begin
            m_cnt = 0;
            m_per = (frequency_divisor < 32'd100) ? 100 : frequency_divisor;
        end else if (enable) begin
            m_cnt++;
        end
        if (m_started && m_left == 0) begin
            if (t) m_under = 1;
            if (mem_ack) begin
                m_word = mem_data;
                m_left = 2;
            end
        end else if (m_left > 0 && t) begin
            m_sample = (m_left == 2) ? m_word[15:0] : m_word[31:16];
            m_valid  = 1;
            m_left--;
            if (m_left == 0) m_addr = (m_addr == LAST) ? '0 : m_addr + 1'b1;
        end
        if (!m_started && enable) m_started = 1;
        m_req = m_started && (m_left == 0);
    endtask

    // Drive the memory side, advance the model, then step past one clock edge.
    task automatic cyc();
        mem_ack  = 1'b0;
        mem_data = $urandom;
        if (stray) begin
            mem_ack = 1'b1;
            stray   = 0;
        end else if (mem_req && !hold) begin
            if (wcnt >= lat) begin
                mem_ack       = 1'b1;
                mem_data      = fixed_en ? fixed_data : $urandom;
                last_ack_data = mem_data;
                wcnt          = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        model_step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; restart = 1'b0; mem_ack = 1'b0; mem_data = '0;
        frequency_divisor = 32'd1136;
        hold = 0; stray = 0; fixed_en = 0; lat = 3; fixed_data = '0; last_ack_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL reset_values got %h exp 0", dut_vec());
        end
        reset_n = 1'b1;
        cycle   = 0;
    endtask

    task automatic test_basic();
        int nv = 0;
        int t[2];
        logic [15:0] s[2];
        enable = 1'b1; fixed_en = 1; fixed_data = 32'hBEEF_1234; lat = 3;
        for (int k = 0; k < 3000 && nv < 2; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL basic_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (sample_valid) begin
                t[nv] = cycle; s[nv] = sample_out; nv++;
            end
        end
        checks++;
        if (nv !== 2) begin
            errors++;
            $display("FAIL basic_timeout got %0d valids exp 2", nv);
        end else begin
            checks += 5;
            if (t[0] !== 1136) begin errors++; $display("FAIL basic_first_time got %0d exp 1136", t[0]); end
            if (s[0] !== 16'h1234) begin errors++; $display("FAIL basic_lo got %h exp 1234", s[0]); end
            if (s[1] !== 16'hBEEF) begin errors++; $display("FAIL basic_hi got %h exp beef", s[1]); end
            if (t[1] - t[0] !== 1136) begin errors++; $display("FAIL basic_gap got %0d exp 1136", t[1] - t[0]); end
            if ({mem_req, mem_addr} !== {1'b1, 23'd1}) begin
                errors++;
                $display("FAIL basic_next_fetch got req %b addr %0d exp req 1 addr 1", mem_req, mem_addr);
            end
        end
        fixed_en = 0;
    endtask

    task automatic test_divisor();
        int iv[6];
        int nv    = 0;
        int tprev = cycle;
        iv = '{1136, 1036, 1036, 100, 100, 100};
        for (int k = 0; k < 4000 && nv < 6; k++) begin
            if (nv == 0 && m_cnt == 500) frequency_divisor = 32'd1036;
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL divisor_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (sample_valid) begin
                checks++;
                if (cycle - tprev !== iv[nv]) begin
                    errors++;
                    $display("FAIL divisor_period%0d got %0d exp %0d", nv, cycle - tprev, iv[nv]);
                end
                tprev = cycle;
                nv++;
                if (nv == 2) frequency_divisor = 32'd5;
                if (nv == 4) frequency_divisor = 32'd0;
            end
        end
        checks++;
        if (nv !== 6) begin errors++; $display("FAIL divisor_timeout got %0d exp 6", nv); end
    endtask

    task automatic test_underrun();
        int nu = 0, nvld = 0, ns = 0;
        logic [15:0] held, s[2];
        for (int k = 0; k < 1200 && !mem_req; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL underrun_pre_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
        end
        hold = 1;
        held = m_sample;
        for (int k = 0; k < 400 && nu < 2; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL underrun_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            nu   += int'(underrun);
            nvld += int'(sample_valid);
        end
        checks += 3;
        if (nu !== 2)   begin errors++; $display("FAIL underrun_count got %0d exp 2", nu); end
        if (nvld !== 0) begin errors++; $display("FAIL underrun_valid got %0d exp 0", nvld); end
        if (sample_out !== held) begin errors++; $display("FAIL underrun_hold got %h exp %h", sample_out, held); end
        hold = 0;
        for (int k = 0; k < 400 && ns < 2; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL underrun_resume_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (sample_valid) begin s[ns] = sample_out; ns++; end
        end
        checks++;
        if (ns !== 2 || s[0] !== last_ack_data[15:0] || s[1] !== last_ack_data[31:16]) begin
            errors++;
            $display("FAIL underrun_resume got %0d %h %h exp 2 %h", ns, s[0], s[1], last_ack_data);
        end
    endtask

    task automatic test_restart();
        bit found = 0;
        logic [15:0] held;
        int got = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL restart_pre_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (mem_req && mem_addr == 23'd7) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL restart_reach7 got 0 exp 1"); end
        hold = 1;
        repeat (2) cyc();
        held    = m_sample;
        restart = 1'b1;
        stray   = 1;
        cyc();
        restart = 1'b0;
        checks++;
        if ({mem_req, mem_addr, sample_out} !== {1'b0, 23'd0, held}) begin
            errors++;
            $display("FAIL restart_drop got req %b addr %0d smp %h exp 0 0 %h", mem_req, mem_addr, sample_out, held);
        end
        hold = 0;
        cyc();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 23'd0}) begin
            errors++;
            $display("FAIL restart_refetch got req %b addr %0d exp 1 0", mem_req, mem_addr);
        end
        for (int k = 0; k < 300 && got == 0; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL restart_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (sample_valid) begin
                got = 1;
                checks++;
                if (sample_out !== last_ack_data[15:0]) begin
                    errors++;
                    $display("FAIL restart_sample got %h exp %h", sample_out, last_ack_data[15:0]);
                end
            end
        end
        checks++;
        if (got !== 1) begin errors++; $display("FAIL restart_timeout got 0 exp 1"); end
    endtask

    task automatic test_reset_mid_fetch();
        bit found = 0;
        int got = 0;
        for (int k = 0; k < 3000 && !found; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_pre_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (mem_req && mem_addr == 23'd7) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach7 got 0 exp 1"); end
        hold    = 1;
        reset_n = 1'b0;
        #2;
        checks++;
        if (dut_vec() !== '0) begin
            errors++;
            $display("FAIL rstmid_async got %h exp 0", dut_vec());
        end
        model_reset();
        @(posedge clk);
        #1;
        cycle++;
        reset_n = 1'b1;
        enable  = 1'b0;
        hold    = 0;
        stray   = 1;
        repeat (4) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_idle_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({mem_req, mem_addr, sample_valid} !== '0) begin
            errors++;
            $display("FAIL rstmid_stray got req %b addr %0d exp 0 0", mem_req, mem_addr);
        end
        enable = 1'b1;
        for (int k = 0; k < 1500 && got == 0; k++) begin
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (sample_valid) begin
                got = 1;
                checks++;
                if (sample_out !== last_ack_data[15:0]) begin
                    errors++;
                    $display("FAIL rstmid_sample got %h exp %h", sample_out, last_ack_data[15:0]);
                end
            end
        end
        checks++;
        if (got !== 1) begin errors++; $display("FAIL rstmid_timeout got 0 exp 1"); end
    endtask

    task automatic test_wrap();
        bit wrapped = 0;
        logic [ADDR_W-1:0] prev;
        for (int k = 0; k < 5000 && !wrapped; k++) begin
            prev = mem_addr;
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
            if (prev == LAST && mem_addr != LAST) begin
                wrapped = 1;
                checks++;
                if ({mem_req, mem_addr} !== {1'b1, 23'd0}) begin
                    errors++;
                    $display("FAIL wrap_addr got req %b addr %0d exp 1 0", mem_req, mem_addr);
                end
            end
        end
        checks++;
        if (!wrapped) begin errors++; $display("FAIL wrap_timeout got 0 exp 1"); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6000; k++) begin
            enable  = ($urandom_range(0, 15) != 0);
            restart = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) == 0)
                frequency_divisor = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99)
                                                                : $urandom_range(100, 160);
            if ($urandom_range(0, 49) == 0) hold = ~hold;
            if ($urandom_range(0, 19) == 0) lat = $urandom_range(0, 5);
            if (!mem_req && $urandom_range(0, 59) == 0) stray = 1;
            cyc();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_cycle%0d got %h exp %h", cycle, dut_vec(), exp_vec());
            end
        end
        restart = 1'b0;
        hold    = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divisor();
        test_underrun();
        test_restart();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
